bsearch_initiator: RTL and testbench
====================================

Name: bsearch_initiator

Overview:
- Sequential initiator for the lesser/equal/greater comparator interface. The comparator is the responder; this block drives its probe operand and consumes its three flags.
- Runs a binary search over [0, 2^WIDTH-1] to find the value held on the comparator's other operand (the target).
- Used to resolve an unknown value behind a comparator with at most WIDTH+1 comparisons.
- Sits beside an existing combinational comparator instance: probe goes to comparator in1; the target drives in2.

Parameters:
- WIDTH, 3, operand width in bits; search range is 0 to 2^WIDTH-1.
- STEP_W, $clog2(WIDTH+2), width of the step counter (localparam, derived).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- probe  out  WIDTH  registered operand driven to comparator in1
- cmp_lesser  in  1  probe < target (combinational response to probe)
- cmp_equal  in  1  probe == target
- cmp_greater  in  1  probe > target
- busy  out  1  high in SEARCH
- done  out  1  one-cycle pulse when the search ends
- found  out  1  target located; valid from done, held until next accepted start
- error  out  1  protocol violation seen; held like found
- result  out  WIDTH  located value when found=1, else 0
- steps  out  STEP_W  number of comparisons performed

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; probe=0, busy=0, done=0, found=0, error=0, result=0, steps=0; lo=0, hi=2^WIDTH-1. Reset overrides everything, including mid-search.
- States are IDLE, SEARCH and DONE.
- IDLE:
  - start=1 → SEARCH next cycle with lo=0, hi=MAX, probe=MAX>>1, steps=0, found=0, error=0, result=0.
  - start=0 → stay in IDLE; all outputs hold.
- SEARCH: busy=1. Flags are sampled every cycle against the current probe, which is stable for the whole cycle. The comparator is combinational, so there is no wait state. Each cycle steps increments by 1. The first matching rule below applies:
  - flags not one-hot (none set, or more than one set) → error=1, found=0 → DONE.
  - cmp_equal → found=1, result=probe → DONE.
  - cmp_lesser with probe==hi → found=0 → DONE (window exhausted).
  - cmp_lesser otherwise → lo=probe+1; probe=(probe+1+hi)>>1.
  - cmp_greater with probe==lo → found=0 → DONE (window exhausted, no underflow).
  - cmp_greater otherwise → hi=probe-1; probe=(lo+probe-1)>>1.
- Mid computation uses a WIDTH+1-bit sum, so there is no overflow at MAX.
- DONE: done=1 for exactly one cycle; busy=0; then IDLE. found, error, result and steps hold until the next accepted start.
- start in SEARCH or DONE is ignored; it is not queued.
- Latency: start at edge N → first probe valid after edge N+1 → done visible after edge N+1+steps.
- Step bounds: steps ≤ WIDTH+1 always. A search that finds its target takes ≤ WIDTH steps, except that target MAX needs WIDTH+1.
- probe is registered, not derived combinationally from the flags, so there is no loop through the comparator.

Decomposition:
- Package bsearch_pkg holds:
  - enum state_t {IDLE, SEARCH, DONE};
  - function mid(lo, hi), returning the width-safe midpoint.
- No sub-module. The comparator stays external, so the bench can substitute a misbehaving model.

Test Plan:
- WIDTH=3, target=5 → probes 3,5; done with found=1, result=5, steps=2, error=0.
- Target=0 → probes 3,1,0; found=1, result=0, steps=3. Target=7 → probes 3,5,6,7; found=1, result=7, steps=4.
- Sweep all targets 0..7 against a reference comparator → found=1 and result=target every time; steps ≤ 4; exactly one done pulse per start.
- Stub responder that always asserts lesser → probes 3,5,6,7, then probe==hi; found=0, error=0, steps=4, result=0. Always-greater stub → probes 3,1,0; found=0, steps=3.
- Stub asserting lesser and greater together on the first probe → done after 1 step with error=1, found=0. All flags low → same response.
- start pulse in mid-search is ignored, and the search completes unchanged. A separate run drives rst_n=0 during SEARCH → next edge gives IDLE with all outputs 0; a new start then completes normally.

Source files
------------

// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the binary-search comparator initiator.
package bsearch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Widest operand the midpoint helper supports.
   localparam int MID_W = 32;

   // Midpoint of [lo, hi]; the sum is formed one bit wider so it cannot wrap.
   function automatic logic [MID_W-1:0] mid(input logic [MID_W-1:0] lo,
                                            input logic [MID_W-1:0] hi);
      logic [MID_W:0] sum;
      sum = {1'b0, lo} + {1'b0, hi};
      return MID_W'(sum >> 1);
   endfunction

endpackage

// File: rtl/bsearch_initiator.sv
// Binary-search initiator: drives a registered probe into an external
// combinational comparator and narrows [lo, hi] from its three flags until the
// target is located, the window is exhausted, or the flags are malformed.
module bsearch_initiator
   import bsearch_pkg::*;
#(
   parameter  int WIDTH  = 3,
   localparam int STEP_W = $clog2(WIDTH + 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [WIDTH-1:0]  probe,
   input  logic              cmp_lesser,
   input  logic              cmp_equal,
   input  logic              cmp_greater,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic              error,
   output logic [WIDTH-1:0]  result,
   output logic [STEP_W-1:0] steps
);

   localparam logic [WIDTH-1:0] MAX = '1;

   state_t             state, state_n;
   logic [WIDTH-1:0]   lo, lo_n, hi, hi_n, probe_n, result_n;
   logic [STEP_W-1:0]  steps_n;
   logic               found_n, error_n;

   assign busy = (state == SEARCH);
   assign done = (state == DONE);

   // State and datapath registers; reset clears everything, even mid-search.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         lo     <= '0;
         hi     <= MAX;
         probe  <= '0;
         steps  <= '0;
         found  <= 1'b0;
         error  <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_n;
         lo     <= lo_n;
         hi     <= hi_n;
         probe  <= probe_n;
         steps  <= steps_n;
         found  <= found_n;
         error  <= error_n;
         result <= result_n;
      end
   end

   // Next-state and window update; one comparison is consumed per SEARCH cycle.
   always_comb begin
      state_n  = state;
      lo_n     = lo;
      hi_n     = hi;
      probe_n  = probe;
      steps_n  = steps;
      found_n  = found;
      error_n  = error;
      result_n = result;
      case (state)
         IDLE: begin
            if (start) begin
               state_n  = SEARCH;
               lo_n     = '0;
               hi_n     = MAX;
               probe_n  = MAX >> 1;
               steps_n  = '0;
               found_n  = 1'b0;
               error_n  = 1'b0;
               result_n = '0;
            end
         end
         SEARCH: begin
            steps_n = steps + STEP_W'(1);
            if (!$onehot({cmp_lesser, cmp_equal, cmp_greater})) begin
               error_n = 1'b1;
               found_n = 1'b0;
               state_n = DONE;
            end else if (cmp_equal) begin
               found_n  = 1'b1;
               result_n = probe;
               state_n  = DONE;
            end else if (cmp_lesser) begin
               // Target lies above the probe; nothing left once probe reaches hi.
               if (probe == hi) begin
                  found_n = 1'b0;
                  state_n = DONE;
               end else begin
                  lo_n    = probe + WIDTH'(1);
                  probe_n = WIDTH'(mid(MID_W'(probe + WIDTH'(1)), MID_W'(hi)));
               end
            end else begin
               // Target lies below the probe; stop at lo rather than underflow.
               if (probe == lo) begin
                  found_n = 1'b0;
                  state_n = DONE;
               end else begin
                  hi_n    = probe - WIDTH'(1);
                  probe_n = WIDTH'(mid(MID_W'(lo), MID_W'(probe - WIDTH'(1))));
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bsearch_initiator.sv
// Directed bench for bsearch_initiator with a switchable comparator model.
module tb_bsearch_initiator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] probe;
   logic       cmp_lesser, cmp_equal, cmp_greater;
   logic       busy, done, found, error;
   logic [2:0] result;
   logic [2:0] steps;

   // 0: real comparator, 1: always lesser, 2: always greater,
   // 3: lesser+greater, 4: no flag
   int         mode;
   logic [2:0] target;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bsearch_initiator #(.WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .probe       (probe),
      .cmp_lesser  (cmp_lesser),
      .cmp_equal   (cmp_equal),
      .cmp_greater (cmp_greater),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .error       (error),
      .result      (result),
      .steps       (steps)
   );

   // Comparator responder models
   always_comb begin
      cmp_lesser  = 1'b0;
      cmp_equal   = 1'b0;
      cmp_greater = 1'b0;
      case (mode)
         0: begin
            cmp_lesser  = probe < target;
            cmp_equal   = probe == target;
            cmp_greater = probe > target;
         end
         1: cmp_lesser = 1'b1;
         2: cmp_greater = 1'b1;
         3: begin
            cmp_lesser  = 1'b1;
            cmp_greater = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One search: probe sequence packed 4 bits per probe, oldest in the high nibble.
   task automatic run(input string tag, input int md, input logic [2:0] tgt,
                      input logic ef, input logic ee, input logic [2:0] er,
                      input int es, input logic [15:0] eseq, input int midst);
      logic [15:0] seq;
      int          ndone;
      bit          got;
      seq   = '0;
      ndone = 0;
      got   = 0;
      mode   = md;
      target = tgt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (busy) seq = {seq[11:0], 1'b0, probe};
         if (done) begin
            got = 1;
            ndone++;
            break;
         end
         start = (c == midst);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, ".done_seen"}, 32'(got), 32'd1);
      chk({tag, ".found"},  32'(found),  32'(ef));
      chk({tag, ".error"},  32'(error),  32'(ee));
      chk({tag, ".result"}, 32'(result), 32'(er));
      chk({tag, ".steps"},  32'(steps),  32'(es));
      chk({tag, ".probes"}, 32'(seq),    32'(eseq));
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk({tag, ".one_done"}, 32'(ndone), 32'd1);
      chk({tag, ".idle"},     32'({busy, done}), 32'd0);
      chk({tag, ".hold"},     32'({found, error, result, steps}),
          32'({ef, ee, er, es[2:0]}));
   endtask

   // Expected probe sequences for targets 0..7 with the real comparator
   logic [15:0] sweep_seq [8] = '{16'h0310, 16'h0031, 16'h0312, 16'h0003,
                                  16'h0354, 16'h0035, 16'h0356, 16'h3567};
   int          sweep_steps [8] = '{3, 2, 3, 1, 3, 2, 3, 4};

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 0;
      target = 3'd0;
      repeat (2) @(negedge clk);
      chk("reset.outputs", 32'({probe, busy, done, found, error, result, steps}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle.hold", 32'({probe, busy, done}), 32'd0);

      run("t5", 0, 3'd5, 1'b1, 1'b0, 3'd5, 2, 16'h0035, -1);
      run("t0", 0, 3'd0, 1'b1, 1'b0, 3'd0, 3, 16'h0310, -1);
      run("t7", 0, 3'd7, 1'b1, 1'b0, 3'd7, 4, 16'h3567, -1);

      for (int t = 0; t < 8; t++)
         run($sformatf("sweep%0d", t), 0, 3'(t), 1'b1, 1'b0, 3'(t),
             sweep_steps[t], sweep_seq[t], -1);

      run("all_less", 1, 3'd0, 1'b0, 1'b0, 3'd0, 4, 16'h3567, -1);
      run("all_grtr", 2, 3'd0, 1'b0, 1'b0, 3'd0, 3, 16'h0310, -1);
      run("lt_and_gt", 3, 3'd0, 1'b0, 1'b1, 3'd0, 1, 16'h0003, -1);
      run("no_flag",   4, 3'd0, 1'b0, 1'b1, 3'd0, 1, 16'h0003, -1);

      // start pulses during SEARCH must not disturb the search
      run("mid_start", 0, 3'd7, 1'b1, 1'b0, 3'd7, 4, 16'h3567, 1);

      // Reset during SEARCH
      mode   = 0;
      target = 3'd7;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      chk("rst_mid.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid.outputs", 32'({probe, busy, done, found, error, result, steps}), 32'd0);
      run("after_rst", 0, 3'd5, 1'b1, 1'b0, 3'd5, 2, 16'h0035, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
